// File: rtl/fifo_pkg.sv
// Shared definitions for both sides of the asynchronous FIFO.
// Provides default sizing constants and the binary/Gray pointer conversions,
// so the read and write controllers encode pointers identically.
// Conversions work on a fixed wide word; callers zero-extend their pointer
// into conv_t and size-cast the result back to pointer width.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH      = 8;
    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_PTR_WIDTH  = 3;

    localparam int unsigned CONV_WIDTH = 32;
    typedef logic [CONV_WIDTH-1:0] conv_t;

    function automatic conv_t bin2gray(input conv_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done with doubling shifts.
    function automatic conv_t gray2bin(input conv_t g);
        conv_t b;
        b = g;
        for (int unsigned s = 1; s < CONV_WIDTH; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Valid/ready output register for the FIFO read stream.
// Loads a word whenever the controller pops; otherwise drops valid once the
// downstream accepts, and holds data/valid while stalled.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_pop             load strobe (a word is being consumed from memory)
//   i_rdata           word to load
//   i_ready           downstream ready
//   o_data, o_valid   registered stream output
module fifo_out_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // A pop while the current word is being taken reloads in the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_pop) begin
            r_data  <= i_rdata;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side controller of the asynchronous FIFO (read clock domain only).
// Owns the binary/Gray read pointer and the empty flag, drains memory into a
// registered valid/ready stream and reports a pessimistic occupancy.
// Ports:
//   rclk, rrst     read clock, synchronous active-high reset
//   g_wptr_sync    Gray write pointer, already synchronised into rclk
//   mem_rdata      combinational memory data at b_rptr[PTR_WIDTH-1:0]
//   b_rptr         binary read pointer (memory read address + wrap bit)
//   g_rptr         registered Gray read pointer for the write domain
//   r_en           pop strobe, one cycle per consumed word
//   empty          registered empty flag
//   rd_level       registered occupancy estimate, 0..DEPTH
//   m_data/m_valid/m_ready   output stream
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned PTR_WIDTH  = FIFO_PTR_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [PTR_WIDTH:0]    g_wptr_sync,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  r_en,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    rd_level,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int unsigned PW = PTR_WIDTH + 1;
    typedef logic [PW-1:0] ptr_t;

    if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_check
        $error("fifo_rd_stream: DEPTH must equal 2**PTR_WIDTH");
    end

    ptr_t r_b_rptr;
    ptr_t r_g_rptr;
    logic r_empty;
    ptr_t r_rd_level;

    logic w_pop;
    logic w_m_valid;
    ptr_t w_b_rptr_next;
    ptr_t w_g_rptr_next;
    ptr_t w_wptr_bin;

    assign w_pop         = !r_empty && (!w_m_valid || m_ready);
    assign w_b_rptr_next = r_b_rptr + ptr_t'(w_pop);
    assign w_g_rptr_next = ptr_t'(bin2gray(conv_t'(w_b_rptr_next)));
    assign w_wptr_bin    = ptr_t'(gray2bin(conv_t'(g_wptr_sync)));

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_b_rptr   <= '0;
            r_g_rptr   <= '0;
            r_empty    <= 1'b1;
            r_rd_level <= '0;
        end else begin
            r_b_rptr   <= w_b_rptr_next;
            r_g_rptr   <= w_g_rptr_next;
            // Full-width Gray compare makes pointer wrap transparent.
            r_empty    <= (w_g_rptr_next == g_wptr_sync);
            // Modular difference; the synchronised write pointer lags, so
            // this never overstates what is really stored.
            r_rd_level <= w_wptr_bin - w_b_rptr_next;
        end
    end

    fifo_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .i_clk   (rclk),
        .i_rst   (rrst),
        .i_pop   (w_pop),
        .i_rdata (mem_rdata),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_valid (w_m_valid)
    );

    assign b_rptr   = r_b_rptr;
    assign g_rptr   = r_g_rptr;
    assign r_en     = w_pop;
    assign empty    = r_empty;
    assign rd_level = r_rd_level;
    assign m_valid  = w_m_valid;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic       rclk;
    logic       rrst;
    logic [3:0] g_wptr_sync;
    logic [7:0] mem_rdata;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       r_en;
    logic       empty;
    logic [3:0] rd_level;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    logic [7:0] mem [8];

    int checks = 0;
    int errors = 0;

    fifo_rd_stream #(
        .DEPTH(8),
        .DATA_WIDTH(8),
        .PTR_WIDTH(3)
    ) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .g_wptr_sync (g_wptr_sync),
        .mem_rdata   (mem_rdata),
        .b_rptr      (b_rptr),
        .g_rptr      (g_rptr),
        .r_en        (r_en),
        .empty       (empty),
        .rd_level    (rd_level),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    assign mem_rdata = mem[b_rptr[2:0]];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [3:0] gray(input int unsigned v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    // Advance one edge; sample and drive 1 time unit later.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic apply_reset();
        rrst        = 1'b1;
        m_ready     = 1'b0;
        g_wptr_sync = 4'd0;
        tick();
        tick();
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        rrst        = 1'b1;
        m_ready     = 1'b0;
        g_wptr_sync = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got %0b want 0", r_en); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
        checks++;
        if (b_rptr !== 4'd0 || g_rptr !== 4'd0) begin
            errors++; $display("FAIL reset_ptrs got b=%0d g=%0d want 0 0", b_rptr, g_rptr);
        end
        checks++;
        if (rd_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", rd_level); end
        rrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (r_en !== 1'b0 || empty !== 1'b1 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle got r_en=%0b empty=%0b m_valid=%0b want 0 1 0", r_en, empty, m_valid);
            end
        end
    endtask

    task automatic test_single_word();
        apply_reset();
        mem[0]      = 8'hA5;
        m_ready     = 1'b1;
        g_wptr_sync = 4'd1;
        tick();
        checks++;
        if (empty !== 1'b0 || r_en !== 1'b1 || m_valid !== 1'b0 || rd_level !== 4'd1) begin
            errors++;
            $display("FAIL single_visible got empty=%0b r_en=%0b valid=%0b level=%0d want 0 1 0 1",
                     empty, r_en, m_valid, rd_level);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            errors++; $display("FAIL single_out got valid=%0b data=%h want 1 a5", m_valid, m_data);
        end
        checks++;
        if (b_rptr !== 4'd1 || g_rptr !== 4'd1 || empty !== 1'b1 || rd_level !== 4'd0) begin
            errors++;
            $display("FAIL single_ptr got b=%0d g=%0d empty=%0b level=%0d want 1 1 1 0",
                     b_rptr, g_rptr, empty, rd_level);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || r_en !== 1'b0) begin
            errors++; $display("FAIL single_drop got valid=%0b r_en=%0b want 0 0", m_valid, r_en);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        g_wptr_sync = 4'd2;   // gray(3)
        tick();
        checks++;
        if (empty !== 1'b0 || rd_level !== 4'd3) begin
            errors++; $display("FAIL bp_visible got empty=%0b level=%0d want 0 3", empty, rd_level);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h11 || b_rptr !== 4'd1 || r_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got valid=%0b data=%h b=%0d r_en=%0b want 1 11 1 0",
                         i, m_valid, m_data, b_rptr, r_en);
            end
            tick();
        end
        checks++;
        if (rd_level !== 4'd2) begin errors++; $display("FAIL bp_level got %0d want 2", rd_level); end
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h22 || b_rptr !== 4'd2) begin
            errors++; $display("FAIL bp_word1 got valid=%0b data=%h b=%0d want 1 22 2", m_valid, m_data, b_rptr);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h33 || b_rptr !== 4'd3 || empty !== 1'b1) begin
            errors++;
            $display("FAIL bp_word2 got valid=%0b data=%h b=%0d empty=%0b want 1 33 3 1",
                     m_valid, m_data, b_rptr, empty);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %0b want 0", m_valid); end
    endtask

    task automatic test_back_to_back_wrap();
        int w;
        int rx;
        int first_c;
        int last_c;
        apply_reset();
        m_ready = 1'b1;
        w = 0; rx = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && rx < 20; c++) begin
            if (w < 20) begin
                mem[w % 8]  = 8'(8'h40 + w);
                w++;
                g_wptr_sync = gray(w);
            end
            tick();
            if (m_valid === 1'b1) begin
                checks++;
                if (m_data !== 8'(8'h40 + rx)) begin
                    errors++; $display("FAIL b2b_data[%0d] got %h want %h", rx, m_data, 8'(8'h40 + rx));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                rx++;
            end
            checks++;
            if (g_rptr !== gray(b_rptr)) begin
                errors++; $display("FAIL b2b_gray got g=%h want %h", g_rptr, gray(b_rptr));
            end
            checks++;
            if (rd_level > 4'd8) begin errors++; $display("FAIL b2b_level got %0d want <=8", rd_level); end
        end
        checks++;
        if (rx != 20) begin errors++; $display("FAIL b2b_count got %0d want 20", rx); end
        checks++;
        if (last_c - first_c + 1 != 20) begin
            errors++; $display("FAIL b2b_gaps got span %0d want 20", last_c - first_c + 1);
        end
        tick();
        checks++;
        if (b_rptr !== 4'd4 || g_rptr !== 4'd6 || empty !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got b=%0d g=%0d empty=%0b valid=%0b want 4 6 1 0",
                     b_rptr, g_rptr, empty, m_valid);
        end
    endtask

    task automatic test_level();
        apply_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h80 + i);
        g_wptr_sync = 4'hC;   // gray(8)
        tick();
        checks++;
        if (empty !== 1'b0 || rd_level !== 4'd8) begin
            errors++; $display("FAIL lvl_full got empty=%0b level=%0d want 0 8", empty, rd_level);
        end
        tick();
        checks++;
        if (rd_level !== 4'd7 || b_rptr !== 4'd1 || m_data !== 8'h80) begin
            errors++; $display("FAIL lvl_first got level=%0d b=%0d data=%h want 7 1 80", rd_level, b_rptr, m_data);
        end
        m_ready = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            tick();
            checks++;
            if (rd_level !== 4'(8 - k) || m_data !== 8'(8'h80 + k - 1)) begin
                errors++;
                $display("FAIL lvl_pop[%0d] got level=%0d data=%h want %0d %h",
                         k, rd_level, m_data, 8 - k, 8'(8'h80 + k - 1));
            end
        end
        checks++;
        if (empty !== 1'b1 || rd_level !== 4'd0 || b_rptr !== 4'd8) begin
            errors++; $display("FAIL lvl_empty got empty=%0b level=%0d b=%0d want 1 0 8", empty, rd_level, b_rptr);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'hC0 + i);
        g_wptr_sync = 4'hC;
        m_ready     = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        m_ready = 1'b0;
        checks++;
        if (b_rptr !== 4'd5 || m_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre got b=%0d valid=%0b want 5 1", b_rptr, m_valid);
        end
        rrst = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b0 || b_rptr !== 4'd0 || g_rptr !== 4'd0 || empty !== 1'b1 ||
            rd_level !== 4'd0 || r_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got valid=%0b b=%0d g=%0d empty=%0b level=%0d r_en=%0b want 0 0 0 1 0 0",
                     m_valid, b_rptr, g_rptr, empty, rd_level, r_en);
        end
        g_wptr_sync = 4'd0;
        tick();
        rrst = 1'b0;
    endtask

    initial begin
        rrst        = 1'b1;
        m_ready     = 1'b0;
        g_wptr_sync = 4'd0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back_wrap();
        test_level();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
